vsu_store_serializer: RTL
=========================

// Module: vsu_store_serializer
// PURPOSE
//  Vector store path, the opposite direction of the load path. Reads vector-register words from every lane
//  through the VRF accesser, buffers them per lane, and serializes them word by word to the scalar core's
//  store-data port, lane 0 first. Sits between vinsn_launcher/vrf_accesser and the scalar core; reports done to committer.
// PARAMETERS
//  NrLane      4   number of lanes; power of two, >=2
//  DataWidth   64  VRF word width per lane (bits); ByteBlock = NrLane*DataWidth/8 bytes per block
//  AddrWidth   8   VRF word address width
//  VlBWidth    16  byte-length field width
//  IdWidth     3   instruction id width
//  InBufDepth  2   per-lane read-data FIFO depth (>=2)
// PORTS
//  clk_i            in   1                  clock
//  rst_ni           in   1                  reset, asynchronous, active-low
//  vfu_req_valid_i  in   1                  request valid from vinsn_launcher
//  vfu_req_ready_o  out  1                  unit can take a request
//  target_is_vsu_i  in   1                  request targets this unit
//  req_raddr_i      in   AddrWidth          first VRF word address
//  req_vlB_i        in   VlBWidth           bytes to store
//  req_id_i         in   IdWidth            instruction id
//  rd_valid_o       out  NrLane             per-lane VRF read request
//  rd_gnt_i         in   NrLane             per-lane grant; rd_valid_o[i]&rd_gnt_i[i] = read issued
//  rd_addr_o        out  NrLane*AddrWidth   per-lane read address
//  rd_data_valid_i  in   NrLane             read data returns exactly 1 cycle after grant
//  rd_data_i        in   NrLane*DataWidth   per-lane read data
//  store_op_valid_o out  1                  store word valid to scalar core
//  store_op_ready_i in   1                  scalar core accepts word
//  store_op_o       out  DataWidth          store word
//  store_op_strb_o  out  DataWidth/8        byte enables of store word
//  done_o           out  1                  one-cycle pulse, instruction complete
//  done_insn_id_o   out  IdWidth            id of completed instruction
// BEHAVIOUR
//  Reset: state IDLE, all FIFOs empty, counters 0; vfu_req_ready_o=1, rd_valid_o=0, store_op_valid_o=0, done_o=0.
//  FSM IDLE->STORE on vfu_req_valid_i&target_is_vsu_i: latch raddr, vlB, id; rd_cnt=wr_cnt=ceil(vlB/ByteBlock).
//   vlB==0: no reads and no words; done_o pulses on the next cycle; return to IDLE.
//  Read issue (STORE): rd_valid_o[i]=1 iff lane i has not yet been granted for the current block, rd_cnt>0,
//   and credit[i]>0. rd_addr_o[i]=addr_q for every lane. Lanes are granted independently, in any order.
//   Once all lanes are granted for a block: addr_q+1, rd_cnt-1, clear per-lane granted flags (same edge).
//  Credit: credit[i] = InBufDepth - fifo_usage[i] - inflight[i]; a grant is never issued without credit,
//   so returned data is never dropped. rd_data_valid_i with a full FIFO is an assertion failure.
//  Serializer: runs only when all lane FIFOs are non-empty. Word sel 0..NrLane-1 drives lane[sel] FIFO head.
//   A word transfers on store_op_valid_o&store_op_ready_i. valid is held and data is stable until ready.
//   Byte counter rem starts at vlB. strb = all ones if rem>=DataWidth/8, else low rem bits set.
//   rem is decremented by min(rem,DataWidth/8).
//   After lane NrLane-1 is sent, or on the word that takes rem to 0, all lane FIFOs pop together and sel returns to 0.
//   Words past vlB are never presented; the trailing lane words of the last block are discarded by that pop.
//  Done: done_o=1 and done_insn_id_o=id_q in the same cycle as the transfer that takes rem to 0.
//   In that cycle vfu_req_ready_o=1; a new VSU request accepted in the same cycle starts STORE directly, else go to IDLE.
//  vfu_req_ready_o=0 throughout STORE except in the done cycle. Non-VSU requests never change state.
//  Arithmetic: counters saturate at 0. addr_q wraps modulo 2^AddrWidth.
//  Async reset mid-operation: discard all FIFO contents and in-flight reads; no done_o.
// TESTING
//  vlB=32, lanes return A0..A3: 4 words A0,A1,A2,A3, strb 0xFF each; done_o with id on the 4th transfer; 1 VRF read per lane.
//  vlB=20: 3 words strb 0xFF,0xFF,0x0F; lane3 data discarded; done on word 3; next req sees empty FIFOs.
//  vlB=96, store_op_ready_i low 10 cycles: <=InBufDepth reads per lane outstanding; addresses raddr..raddr+2; no data loss.
//  Skewed grants: lane2 granted 5 cycles after the others: serialization waits; order and addresses are unchanged.
//  Back-to-back requests (id 1 vlB=8, id 2 vlB=40): new request accepted in the done cycle; done pulses for 1 then 2, no idle cycle.
//  vlB=0: done one cycle after accept; no reads; no store words. Reset asserted mid-block: all outputs return to reset values.

Source files
------------

// File: rtl/vsu_store_serializer.sv
// -----------------------------------------------------------------------------
// vsu_store_serializer
//
// Vector store path. Reads one VRF word per lane for each block of the vector,
// buffers the returned words in a small per-lane FIFO and hands them to the
// scalar core one word at a time, lane 0 first. Signals completion of the
// instruction with a one-cycle done pulse.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   vfu_req_valid_i / _ready_o     instruction request handshake
//   target_is_vsu_i                request is addressed to this unit
//   req_raddr_i, req_vlB_i, req_id_i  first VRF word, byte length, id
//   rd_valid_o / rd_gnt_i          per-lane VRF read request and grant
//   rd_addr_o                      per-lane read address (same for all lanes)
//   rd_data_valid_i, rd_data_i     per-lane read data, one cycle after grant
//   store_op_valid_o / _ready_i    store word handshake to the scalar core
//   store_op_o, store_op_strb_o    store word and its byte enables
//   done_o, done_insn_id_o         completion pulse and instruction id
// -----------------------------------------------------------------------------
module vsu_store_serializer #(
    parameter int unsigned NrLane     = 4,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned AddrWidth  = 8,
    parameter int unsigned VlBWidth   = 16,
    parameter int unsigned IdWidth    = 3,
    parameter int unsigned InBufDepth = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          vfu_req_valid_i,
    output logic                          vfu_req_ready_o,
    input  logic                          target_is_vsu_i,
    input  logic [AddrWidth-1:0]          req_raddr_i,
    input  logic [VlBWidth-1:0]           req_vlB_i,
    input  logic [IdWidth-1:0]            req_id_i,
    output logic [NrLane-1:0]             rd_valid_o,
    input  logic [NrLane-1:0]             rd_gnt_i,
    output logic [NrLane*AddrWidth-1:0]   rd_addr_o,
    input  logic [NrLane-1:0]             rd_data_valid_i,
    input  logic [NrLane*DataWidth-1:0]   rd_data_i,
    output logic                          store_op_valid_o,
    input  logic                          store_op_ready_i,
    output logic [DataWidth-1:0]          store_op_o,
    output logic [DataWidth/8-1:0]        store_op_strb_o,
    output logic                          done_o,
    output logic [IdWidth-1:0]            done_insn_id_o
);

    localparam int unsigned StrbW      = DataWidth / 8;
    localparam int unsigned ByteBlock  = NrLane * StrbW;
    localparam int unsigned BlockShift = $clog2(ByteBlock);
    localparam int unsigned SelWidth   = $clog2(NrLane);
    localparam int unsigned PtrWidth   = (InBufDepth > 1) ? $clog2(InBufDepth) : 1;
    localparam int unsigned CntWidth   = $clog2(InBufDepth + 1);

    // StZeroDone is the single cycle spent pulsing done for a zero-length store
    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StStore    = 2'd1;
    localparam logic [1:0] StZeroDone = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [AddrWidth-1:0]      addr_q, addr_d;
    logic [VlBWidth-1:0]       rdCnt_q, rdCnt_d;
    logic [VlBWidth-1:0]       rem_q, rem_d;
    logic [IdWidth-1:0]        id_q, id_d;
    logic [SelWidth-1:0]       sel_q, sel_d;
    logic [NrLane-1:0]         granted_q, granted_d;
    logic [NrLane-1:0]         inflight_q;

    logic [NrLane-1:0][InBufDepth-1:0][DataWidth-1:0] fifoMem_q;
    logic [NrLane-1:0][PtrWidth-1:0]  wptr_q, rptr_q;
    logic [NrLane-1:0][CntWidth-1:0]  usage_q;

    logic [NrLane-1:0] hasCredit, laneNonEmpty, push, rdFire;
    logic              accept, blockDone, storeFire, lastWord, popAll;
    logic [VlBWidth-1:0] reqBlocks;

    // Per-lane credit and FIFO status. Returned data counts against the credit
    // from the grant onwards, so a full FIFO can never receive a word.
    for (genvar i = 0; i < NrLane; i++) begin : gLane
        assign hasCredit[i]    = ({1'b0, usage_q[i]} + (CntWidth+1)'(inflight_q[i]))
                                 < (CntWidth+1)'(InBufDepth);
        assign laneNonEmpty[i] = (usage_q[i] != '0);
        assign push[i]         = rd_data_valid_i[i] & inflight_q[i];
        assign rd_addr_o[i*AddrWidth +: AddrWidth] = addr_q;

        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(rd_data_valid_i[i] && (usage_q[i] == CntWidth'(InBufDepth))));
    end

    // Read issue, serializer handshake and completion decode
    always_comb begin
        rd_valid_o = '0;
        for (int i = 0; i < NrLane; i++) begin
            rd_valid_o[i] = (state_q == StStore) && !granted_q[i] &&
                            (rdCnt_q != '0) && hasCredit[i];
        end
        rdFire    = rd_valid_o & rd_gnt_i;
        blockDone = (|rdFire) && (&(granted_q | rdFire));

        store_op_valid_o = (state_q == StStore) && (&laneNonEmpty) && (rem_q != '0);
        store_op_o       = fifoMem_q[sel_q][rptr_q[sel_q]];
        store_op_strb_o  = '0;
        for (int b = 0; b < StrbW; b++) begin
            store_op_strb_o[b] = (VlBWidth'(b) < rem_q);
        end
        storeFire = store_op_valid_o && store_op_ready_i;
        lastWord  = (rem_q <= VlBWidth'(StrbW));
        popAll    = storeFire && ((sel_q == SelWidth'(NrLane - 1)) || lastWord);

        done_o          = (state_q == StZeroDone) || (storeFire && lastWord);
        done_insn_id_o  = id_q;
        vfu_req_ready_o = (state_q == StIdle) || done_o;
        accept          = vfu_req_ready_o && vfu_req_valid_i && target_is_vsu_i;
        reqBlocks       = VlBWidth'(({1'b0, req_vlB_i} + (VlBWidth+1)'(ByteBlock - 1))
                                    >> BlockShift);
    end

    // Next-state logic. A request accepted in the done cycle overrides the
    // return to idle so consecutive stores run without a gap.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rdCnt_d   = rdCnt_q;
        rem_d     = rem_q;
        id_d      = id_q;
        sel_d     = sel_q;
        granted_d = granted_q | rdFire;

        if (blockDone) begin
            addr_d    = addr_q + AddrWidth'(1);
            rdCnt_d   = (rdCnt_q != '0) ? rdCnt_q - VlBWidth'(1) : '0;
            granted_d = '0;
        end

        if (storeFire) begin
            rem_d = lastWord ? '0 : rem_q - VlBWidth'(StrbW);
            sel_d = popAll ? '0 : sel_q + SelWidth'(1);
        end

        if (done_o) begin
            state_d = StIdle;
        end

        if (accept) begin
            addr_d    = req_raddr_i;
            rem_d     = req_vlB_i;
            id_d      = req_id_i;
            rdCnt_d   = reqBlocks;
            sel_d     = '0;
            granted_d = '0;
            state_d   = (req_vlB_i == '0) ? StZeroDone : StStore;
        end
    end

    // Control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rdCnt_q    <= '0;
            rem_q      <= '0;
            id_q       <= '0;
            sel_q      <= '0;
            granted_q  <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rdCnt_q    <= rdCnt_d;
            rem_q      <= rem_d;
            id_q       <= id_d;
            sel_q      <= sel_d;
            granted_q  <= granted_d;
            inflight_q <= rdFire;
        end
    end

    // FIFO pointers and fill levels; all lanes pop together
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else begin
            for (int i = 0; i < NrLane; i++) begin
                if (push[i]) begin
                    wptr_q[i] <= (wptr_q[i] == PtrWidth'(InBufDepth - 1)) ?
                                 '0 : wptr_q[i] + PtrWidth'(1);
                end
                if (popAll) begin
                    rptr_q[i] <= (rptr_q[i] == PtrWidth'(InBufDepth - 1)) ?
                                 '0 : rptr_q[i] + PtrWidth'(1);
                end
                case ({push[i], popAll})
                    2'b10:   usage_q[i] <= usage_q[i] + CntWidth'(1);
                    2'b01:   usage_q[i] <= usage_q[i] - CntWidth'(1);
                    default: usage_q[i] <= usage_q[i];
                endcase
            end
        end
    end

    // FIFO storage needs no reset; the fill levels say what is valid
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrLane; i++) begin
            if (push[i]) begin
                fifoMem_q[i][wptr_q[i]] <= rd_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

endmodule
